// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-enqueue handshake between the bridge register logic and the UART transmitter.
//   tx_data  (master->slave) byte to enqueue
//   tx_write (master->slave) enqueue strobe, data captured on the same edge
//   tx_full  (slave->master) FIFO holds FIFO_DEPTH bytes
//   tx_empty (slave->master) FIFO holds no bytes
//   tx_busy  (slave->master) a frame is being serialised
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    modport master (output tx_data, tx_write, input tx_full, tx_empty, tx_busy);
    modport slave  (input tx_data, tx_write, output tx_full, tx_empty, tx_busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART 8N1 transmitter, LSB first, back-to-back frames while data is queued.
//   clk       system clock
//   resetn    asynchronous active-low reset; aborts any frame and flushes the FIFO
//   tx_if     slave side of the enqueue handshake (tx_data/tx_write in, tx_full/tx_empty/tx_busy out)
//   uart_tx_o registered serial line, idle high
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    uart_tx_fifo_if.slave  tx_if,
    output logic           uart_tx_o
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          uart_tx_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic          push;
    logic          pop;
    logic          bit_end;

    assign tx_if.tx_full  = count_q == (PW+1)'(FIFO_DEPTH);
    assign tx_if.tx_empty = count_q == '0;
    assign tx_if.tx_busy  = state_q != IDLE;
    assign uart_tx_o      = uart_tx_q;

    assign bit_end = bit_cnt_q == CW'(CLKS_PER_BIT - 1);
    assign push    = tx_if.tx_write && !tx_if.tx_full;
    // The serialiser takes the head either from idle or on the last clock of a stop bit,
    // which is what makes consecutive frames gapless.
    assign pop     = !tx_if.tx_empty && (state_q == IDLE || (state_q == STOP && bit_end));

    always_comb begin
        count_d = push && !pop ? count_q + 1'b1 : !push && pop ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_if.tx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    uart_tx_q <= 1'b1;
                    bit_cnt_q <= '0;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        uart_tx_q <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + 1'b1;
                    if (bit_end) begin
                        uart_tx_q <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + 1'b1;
                    if (bit_end) begin
                        // shift_q[1] is the bit that becomes the LSB after this shift
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            uart_tx_q <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            uart_tx_q <= shift_q[1];
                        end
                    end
                end
                default: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            shift_q   <= mem_q[rd_ptr_q];
                            uart_tx_q <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench against a frame-level model and a line receiver.
module tb_uart_tx_fifo;
    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_tx;
    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .tx_if(bus), .uart_tx_o(uart_tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Frame-level model: pending bytes, and the frame on the line with clocks left in it.
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] m_byte;
    bit         m_busy = 0;
    int         m_t = 0;

    function automatic logic exp_line();
        int idx;
        if (!m_busy) return 1'b1;
        idx = (FRAME - m_t) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    task automatic model_edge(bit wr, logic [7:0] d);
        bit full;
        full = q.size() == DEPTH;
        if (m_busy) begin
            m_t--;
            if (m_t == 0) m_busy = 0;
        end
        if (!m_busy && q.size() > 0) begin
            m_byte = q.pop_front();
            m_busy = 1;
            m_t = FRAME;
        end
        if (wr && !full) begin
            q.push_back(d);
            sent.push_back(d);
        end
    endtask

    // Line receiver sampling mid-bit, independent of the model.
    logic [7:0] rx_q[$];
    bit         rx_act = 0;
    logic       rx_prev = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] rx_sh;

    always @(negedge clk) begin
        if (!resetn) begin
            rx_act = 0;
            rx_prev = 1'b1;
        end else if (!rx_act) begin
            if (rx_prev && !uart_tx) begin
                rx_act = 1;
                rx_cnt = 0;
            end
            rx_prev = uart_tx;
        end else begin
            rx_cnt++;
            if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_sh = {uart_tx, rx_sh[7:1]};
            if (rx_cnt == 95) begin
                check("rx_stop", uart_tx, 1);
                rx_q.push_back(rx_sh);
                rx_act = 0;
                rx_prev = uart_tx;
            end
        end
    end

    int   falls[$];
    logic line_prev = 1'b1;

    task automatic step(bit wr, logic [7:0] d);
        @(negedge clk);
        check("uart_tx", uart_tx, exp_line());
        check("tx_busy", bus.tx_busy, m_busy);
        check("tx_empty", bus.tx_empty, q.size() == 0);
        check("tx_full", bus.tx_full, q.size() == DEPTH);
        if (line_prev && !uart_tx) falls.push_back(cyc);
        line_prev = uart_tx;
        bus.tx_write = wr;
        bus.tx_data = d;
        @(posedge clk);
        cyc++;
        if (resetn) model_edge(wr, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 8'h00);
    endtask

    task automatic compare_rx();
        check("rx_count", rx_q.size(), sent.size());
        for (int i = 0; i < rx_q.size() && i < sent.size(); i++) check("rx_byte", rx_q[i], sent[i]);
        rx_q.delete();
        sent.delete();
    endtask

    initial begin
        int gap;
        bit burst;
        bus.tx_write = 1'b0;
        bus.tx_data = 8'h00;
        idle(3);
        @(negedge clk);
        resetn = 1'b1;
        // reset state and 500 quiet clocks
        idle(500);
        // single 0x55 frame
        step(1, 8'h55);
        idle(120);
        compare_rx();
        // six back-to-back writes, last one dropped
        for (int i = 1; i <= 6; i++) step(1, 8'(i));
        check("full_after_burst", bus.tx_full, 1);
        check("drop_count", sent.size(), 5);
        idle(600);
        compare_rx();
        // loopback patterns
        step(1, 8'h00);
        step(1, 8'hFF);
        step(1, 8'hA5);
        idle(350);
        compare_rx();
        // reset mid-DATA with two bytes queued
        step(1, 8'h3C);
        step(1, 8'h11);
        step(1, 8'h22);
        idle(40);
        check("queued_before_reset", bus.tx_empty, 0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("reset_line", uart_tx, 1);
        check("reset_busy", bus.tx_busy, 0);
        check("reset_empty", bus.tx_empty, 1);
        check("reset_full", bus.tx_full, 0);
        q.delete();
        m_busy = 0;
        m_t = 0;
        idle(3);
        @(negedge clk);
        resetn = 1'b1;
        rx_q.delete();
        sent.delete();
        @(posedge clk);
        cyc++;
        idle(200);
        compare_rx();
        // write on the final STOP edge with an empty FIFO
        falls.delete();
        step(1, 8'hFF);
        idle(FRAME);
        step(1, 8'h5A);
        idle(250);
        check("falls_seen", falls.size() >= 2, 1);
        gap = falls.size() >= 2 ? falls[1] - falls[0] : 0;
        check("stop_edge_gap", gap == FRAME || gap == FRAME + 1, 1);
        compare_rx();
        // randomized traffic with bursts
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) burst = !burst;
            step($urandom_range(0, 99) < (burst ? 60 : 4), 8'($urandom));
        end
        idle(700);
        compare_rx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
